// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between a memory initiator and dmem_responder.
// state_dbg exposes the responder FSM state for monitors and checkers.
interface dmem_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic [1:0]  state_dbg;

  modport master (
    output Addr, DataIn, Rd, Wr, createdump,
    input  DataOut, Done, Stall, CacheHit, err, state_dbg
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr, createdump,
    output DataOut, Done, Stall, CacheHit, err, state_dbg
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: 16-bit word memory with a fixed-latency miss path; macro DMEM_CACHE_EN adds an
// 8-line direct-mapped write-through cache, macro DMEM_SIM_DUMP enables the createdump dump.
module dmem_responder #(
  parameter int MEM_AW   = 10,
  parameter int MISS_LAT = 4
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic [15:0]       mem [DEPTH];
  logic [DEPTH-1:0]  word_ok;
  logic [15:0]       data_q;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] cap_idx;
  logic [15:0]       cap_data;
  logic              cap_rd;

  logic [MEM_AW-1:0] idx;
  logic              req;
  logic              illegal;
  logic              hit;
  logic [15:0]       hit_data;
  logic [15:0]       miss_data;
  logic              done;
  logic              stall;
  logic              cache_hit;
  logic              err;
  logic [15:0]       data_out;
  logic              unused_bits;

  // Handshake: a request (Rd|Wr) is only looked at in IDLE; Stall=1 means the initiator holds
  // it while the responder works from captured copies; Done=1 marks the single completion cycle.
  assign idx         = bus.Addr[MEM_AW:1];
  assign req         = bus.Rd | bus.Wr;
  assign illegal     = (bus.Rd & bus.Wr) | (req & bus.Addr[0]);
  // A word never written since reset reads as zero, so reset needs no sweep of the array.
  assign miss_data   = word_ok[cap_idx] ? mem[cap_idx] : 16'h0000;
  assign unused_bits = ^{bus.createdump, bus.Addr};

`ifdef DMEM_CACHE_EN
  logic [15:0] line_data [8];
  logic [11:0] line_tag [8];
  logic [7:0]  line_valid;
  logic [2:0]  cap_line;
  logic [11:0] cap_tag;

  assign hit      = line_valid[bus.Addr[3:1]] && (line_tag[bus.Addr[3:1]] == bus.Addr[15:4]);
  assign hit_data = line_data[bus.Addr[3:1]];
`else
  assign hit      = 1'b0;
  assign hit_data = 16'h0000;
`endif

  always_comb begin
    done      = 1'b0;
    stall     = 1'b0;
    cache_hit = 1'b0;
    err       = 1'b0;
    data_out  = data_q;
    unique case (state)
      IDLE: begin
        if (!rst && req) begin
          if (illegal) begin
            err  = 1'b1;
            done = 1'b1;
          end else if (hit) begin
            done      = 1'b1;
            cache_hit = 1'b1;
            if (bus.Rd) data_out = hit_data;
          end else begin
            stall = 1'b1;
          end
        end
      end
      WAIT: stall = 1'b1;
      DONE: begin
        done = 1'b1;
        if (cap_rd) data_out = miss_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      word_ok  <= '0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_rd   <= 1'b0;
`ifdef DMEM_CACHE_EN
      line_valid <= '0;
      cap_line   <= '0;
      cap_tag    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req && !illegal) begin
            if (hit) begin
              if (bus.Wr) begin
                mem[idx]     <= bus.DataIn;
                word_ok[idx] <= 1'b1;
`ifdef DMEM_CACHE_EN
                line_data[bus.Addr[3:1]] <= bus.DataIn;
`endif
              end else begin
                data_q <= hit_data;
              end
            end else begin
              cap_idx  <= idx;
              cap_data <= bus.DataIn;
              cap_rd   <= bus.Rd;
              cnt      <= '0;
              state    <= WAIT;
`ifdef DMEM_CACHE_EN
              cap_line <= bus.Addr[3:1];
              cap_tag  <= bus.Addr[15:4];
`endif
            end
          end
        end
        WAIT: begin
          if (cnt == 4'(MISS_LAT - 1)) state <= DONE;
          else cnt <= cnt + 4'd1;
        end
        DONE: begin
          state <= IDLE;
          if (cap_rd) begin
            data_q <= miss_data;
`ifdef DMEM_CACHE_EN
            line_data[cap_line]  <= miss_data;
            line_tag[cap_line]   <= cap_tag;
            line_valid[cap_line] <= 1'b1;
`endif
          end else begin
            mem[cap_idx]     <= cap_data;
            word_ok[cap_idx] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_SIM_DUMP
  always @(posedge clk) begin
    if (!rst && state == IDLE && bus.createdump) begin
      for (int i = 0; i < DEPTH; i++)
        if (word_ok[i] && mem[i] != 16'h0000) $display("%h %h", 16'(i << 1), mem[i]);
    end
  end
`endif

  assign bus.DataOut   = data_out;
  assign bus.Done      = done;
  assign bus.Stall     = stall;
  assign bus.CacheHit  = cache_hit;
  assign bus.err       = err;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: transaction-level model of the responder predicts every output cycle;
// a negedge compare process checks the DUT against an expected queue.
module tb_dmem_responder;
  localparam int MEM_AW   = 10;
  localparam int MISS_LAT = 4;
`ifdef DMEM_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif
  localparam logic [20:0] NOCHK = 21'd0;

  logic clk;
  logic rst;
  dmem_if bus();

  dmem_responder #(.MEM_AW(MEM_AW), .MISS_LAT(MISS_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [20:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          run_len = 0;
  int          seen_run = 0;
  logic        seen_hit = 1'b0;
  logic        seen_err = 1'b0;
  logic [15:0] seen_data = 16'h0;

  // behavioural model
  logic [15:0] m_mem [1 << MEM_AW];
  logic        m_valid [8];
  logic [11:0] m_tag [8];
  logic [15:0] m_line [8];
  logic [15:0] last;
  logic [15:0] pool [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, want);
    end
  endtask

  function automatic logic [20:0] ex(input logic d, input logic s, input logic h,
                                     input logic e, input logic [15:0] v);
    return {1'b1, d, s, h, e, v};
  endfunction

  always @(negedge clk) begin
    logic [20:0] e;
    logic [19:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {bus.Done, bus.Stall, bus.CacheHit, bus.err, bus.DataOut};
      if (e[20]) check("cycle_outputs", 32'(act), 32'(e[19:0]));
    end
    if (bus.Stall === 1'b1) begin
      run_len++;
    end else if (bus.Done === 1'b1) begin
      seen_run  = run_len;
      seen_hit  = bus.CacheHit;
      seen_err  = bus.err;
      seen_data = bus.DataOut;
      run_len   = 0;
    end else begin
      run_len = 0;
    end
  end

  // driver tasks
  task automatic step(input logic r, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [15:0] d, input logic [20:0] e);
    @(posedge clk);
    #1;
    rst = r;
    bus.Rd = rd;
    bus.Wr = wr;
    bus.Addr = a;
    bus.DataIn = d;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << MEM_AW); i++) m_mem[i] = 16'h0;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    last = 16'h0;
  endtask

  task automatic do_reset();
    model_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, NOCHK);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, NOCHK);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, ex(1'b0, 1'b0, 1'b0, 1'b0, last));
  endtask

  // One cycle of don't-care request inputs while the responder is busy.
  task automatic busy_step(input logic [20:0] e);
    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         16'($urandom()), 16'($urandom()), e);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    int          w;
    int          li;
    logic [11:0] tg;
    logic        hit;
    w  = int'(a[MEM_AW:1]);
    li = int'(a[3:1]);
    tg = a[15:4];
    if ((rd && wr) || ((rd || wr) && a[0])) begin
      step(1'b0, rd, wr, a, d, ex(1'b1, 1'b0, 1'b0, 1'b1, last));
      return;
    end
    hit = CACHE_EN && m_valid[li] && (m_tag[li] == tg);
    if (hit) begin
      if (rd) last = m_line[li];
      step(1'b0, rd, wr, a, d, ex(1'b1, 1'b0, 1'b1, 1'b0, last));
      if (wr) begin
        m_mem[w]   = d;
        m_line[li] = d;
      end
    end else begin
      step(1'b0, rd, wr, a, d, ex(1'b0, 1'b1, 1'b0, 1'b0, last));
      for (int i = 0; i < MISS_LAT; i++) busy_step(ex(1'b0, 1'b1, 1'b0, 1'b0, last));
      if (rd) begin
        last        = m_mem[w];
        m_valid[li] = 1'b1;
        m_tag[li]   = tg;
        m_line[li]  = m_mem[w];
      end else begin
        m_mem[w] = d;
      end
      busy_step(ex(1'b1, 1'b0, 1'b0, 1'b0, last));
    end
  endtask

  initial begin
    logic [15:0] a;
    int          k;
    rst = 1'b1;
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
    bus.Addr = 16'h0;
    bus.DataIn = 16'h0;
    bus.createdump = 1'b0;
    pool[0] = 16'h0000;
    pool[1] = 16'h0100;
    pool[2] = 16'h0800;
    pool[3] = 16'h4100;

    do_reset();
    idle();

    // cold read miss
    access(1'b1, 1'b0, 16'h0010, 16'h0);
    idle();
    check("cold_stall_cycles", 32'(seen_run), 32'd5);
    check("cold_data", 32'(seen_data), 32'h0000);
    check("cold_hit", 32'(seen_hit), 32'd0);

    // write then read then repeat read
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    idle();
    check("wr_miss_stall_cycles", 32'(seen_run), 32'd5);
    access(1'b1, 1'b0, 16'h0010, 16'h0);
    idle();
    check("rd_after_wr_data", 32'(seen_data), 32'hBEEF);
    check("rd_after_wr_stall", 32'(seen_run), 32'd5);
    access(1'b1, 1'b0, 16'h0010, 16'h0);
    idle();
    check("repeat_rd_data", 32'(seen_data), 32'hBEEF);
    check("repeat_rd_hit", 32'(seen_hit), 32'(CACHE_EN));
    check("repeat_rd_stall", 32'(seen_run), CACHE_EN ? 32'd0 : 32'd5);

    // conflict eviction
    access(1'b1, 1'b0, 16'h0110, 16'h0);
    idle();
    check("conflict_stall", 32'(seen_run), 32'd5);
    access(1'b1, 1'b0, 16'h0010, 16'h0);
    idle();
    check("evicted_stall", 32'(seen_run), 32'd5);
    check("evicted_data", 32'(seen_data), 32'hBEEF);

    // error cases
    access(1'b1, 1'b0, 16'h0011, 16'h0);
    idle();
    check("odd_addr_err", 32'(seen_err), 32'd1);
    access(1'b1, 1'b1, 16'h0010, 16'h1111);
    idle();
    check("rd_wr_err", 32'(seen_err), 32'd1);
    access(1'b0, 1'b1, 16'h0011, 16'hDEAD);
    access(1'b1, 1'b0, 16'h0010, 16'h0);
    idle();
    check("err_no_write", 32'(seen_data), 32'hBEEF);

    // reset during the WAIT of a write miss
    step(1'b0, 1'b0, 1'b1, 16'h0020, 16'h1234, ex(1'b0, 1'b1, 1'b0, 1'b0, last));
    busy_step(ex(1'b0, 1'b1, 1'b0, 1'b0, last));
    busy_step(ex(1'b0, 1'b1, 1'b0, 1'b0, last));
    model_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, NOCHK);
    idle();
    access(1'b1, 1'b0, 16'h0020, 16'h0);
    idle();
    check("abort_rd_data", 32'(seen_data), 32'h0000);
    check("abort_rd_stall", 32'(seen_run), 32'd5);

    // randomized traffic over a small address pool so lines hit, conflict and alias
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 19);
      a = pool[$urandom_range(0, 3)] | 16'($urandom_range(0, 7) << 1);
      if (k == 0) begin
        a[0] = 1'b1;
        access(1'b1, 1'b0, a, 16'h0);
      end else if (k == 1) begin
        access(1'b1, 1'b1, a, 16'($urandom()));
      end else if (k < 12) begin
        access(1'b1, 1'b0, a, 16'h0);
      end else begin
        access(1'b0, 1'b1, a, 16'($urandom()));
      end
      if ($urandom_range(0, 3) == 0) idle();
    end

    idle();
    idle();
    @(posedge clk);
    @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
